// File: rtl/reset_gen.sv
// Reset stretcher with optional watchdog: holds nRESET_SYS low for HOLD_CYCLES after any reset cause.
// Define NEO_WATCHDOG_EN to enable the TICK/WDCLR watchdog and the sticky WD_FIRED flag.
module reset_gen #(
    parameter int WD_TIMEOUT  = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic CLK_24MB,
    input  logic nRESET,
    input  logic TICK,
    input  logic WDCLR,
    output logic nRESET_SYS,
    output logic WD_FIRED
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              nrst_sys_q, nrst_sys_d;
    logic              wd_expire;

`ifdef NEO_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_TIMEOUT - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            fired_q, fired_d;

    // A kick always wins over a simultaneous tick, so expiry requires WDCLR low.
    assign wd_expire = (state_q == ST_RUN) && TICK && !WDCLR && (wd_q == WD_LAST);

    always_comb begin
        wd_d    = wd_q;
        fired_d = fired_q;
        if (state_q == ST_HOLD) begin
            wd_d = '0;
        end else if (WDCLR) begin
            wd_d = '0;
        end else if (TICK) begin
            if (wd_q == WD_LAST) begin
                wd_d    = '0;
                fired_d = 1'b1;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
    end

    always_ff @(posedge CLK_24MB) begin
        if (!nRESET) begin
            wd_q    <= '0;
            fired_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            fired_q <= fired_d;
        end
    end

    assign WD_FIRED = fired_q;
`else
    localparam int unused_wd_timeout = WD_TIMEOUT;
    logic unused_wd_inputs;

    assign unused_wd_inputs = ^{TICK, WDCLR};
    assign wd_expire        = 1'b0;
    assign WD_FIRED         = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        nrst_sys_d = nrst_sys_q;
        case (state_q)
            ST_HOLD: begin
                hold_d = hold_q - HOLD_W'(1);
                // The edge that consumes the last hold count is the one that releases.
                if (hold_q <= HOLD_W'(1)) begin
                    hold_d     = '0;
                    state_d    = ST_RUN;
                    nrst_sys_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (wd_expire) begin
                    state_d    = ST_HOLD;
                    hold_d     = HOLD_LOAD;
                    nrst_sys_d = 1'b0;
                end
            end
            default: begin
                state_d    = ST_HOLD;
                hold_d     = HOLD_LOAD;
                nrst_sys_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_24MB) begin
        if (!nRESET) begin
            state_q    <= ST_HOLD;
            hold_q     <= HOLD_LOAD;
            nrst_sys_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            nrst_sys_q <= nrst_sys_d;
        end
    end

    assign nRESET_SYS = nrst_sys_q;

endmodule
